pipe_stall_ctrl: RTL

Pipeline stall controller for the five-stage core. It generates the 6-bit `stall` vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It merges the ID load-use request, the EX level request, and an internal countdown for fixed-latency multi-cycle EX operations (MADD/MSUB-class). The countdown lets EX issue a single start pulse instead of holding a request. An optional set of stall performance counters is included.

---
 rtl/pipe_stall_ctrl_if.sv | 43 ++++
 rtl/pipe_stall_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// Stall controller bundle: hazard requests and multi-cycle
// EX controls in, stall vector, status and perf counters out.
interface pipe_stall_ctrl_if;
   logic        stallreq_from_id;
   logic        stallreq_from_ex;
   logic        ex_mc_start;
   logic [3:0]  ex_mc_cycles;
   logic        ex_mc_annul;
   logic        perf_clr;
   logic [5:0]  stall;
   logic        mc_busy;
   logic        mc_done;
   logic [31:0] stall_cycles;
   logic [15:0] mc_ops;

   modport master (
      output stallreq_from_id,
      output stallreq_from_ex,
      output ex_mc_start,
      output ex_mc_cycles,
      output ex_mc_annul,
      output perf_clr,
      input  stall,
      input  mc_busy,
      input  mc_done,
      input  stall_cycles,
      input  mc_ops
   );

   modport slave (
      input  stallreq_from_id,
      input  stallreq_from_ex,
      input  ex_mc_start,
      input  ex_mc_cycles,
      input  ex_mc_annul,
      input  perf_clr,
      output stall,
      output mc_busy,
      output mc_done,
      output stall_cycles,
      output mc_ops
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Five-stage pipeline stall controller with multi-cycle EX countdown.
// Define STALL_PERF_CNT_EN to build the stall/op performance counters.
module pipe_stall_ctrl (
   input  logic             clk,
   input  logic             rst,
   pipe_stall_ctrl_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [3:0] cnt;
   logic [3:0] cnt_nx;
   logic       done_q;
   logic       done_nx;
   logic       start_q;
   logic       mc_term;
   logic       ex_req;
   logic       hold_ex;
   logic       hold_id;
   logic [5:0] stall;

   assign start_q = bus.ex_mc_start
                  & ~bus.ex_mc_annul
                  & (state == IDLE)
                  & (bus.ex_mc_cycles >= 4'd2);

   assign mc_term = start_q
                  | ((state == BUSY) & ~bus.ex_mc_annul);

   assign ex_req = bus.stallreq_from_ex | mc_term;

   // EX outranks ID; reset low masks every hold request
   assign hold_ex = rst & ex_req;
   assign hold_id = rst & ~ex_req & bus.stallreq_from_id;

   always_comb begin
      stall = 6'b000000;
      unique case (1'b1)
         hold_ex: stall = 6'b001111;
         hold_id: stall = 6'b000111;
         default: stall = 6'b000000;
      endcase
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      done_nx  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_q) begin
               if (bus.ex_mc_cycles == 4'd2) begin
                  done_nx = 1'b1;
               end else begin
                  state_nx = BUSY;
                  cnt_nx   = bus.ex_mc_cycles - 4'd2;
               end
            end
         end
         BUSY: begin
            if (bus.ex_mc_annul) begin
               state_nx = IDLE;
               cnt_nx   = 4'd0;
            end else if (cnt == 4'd1) begin
               state_nx = IDLE;
               cnt_nx   = 4'd0;
               done_nx  = 1'b1;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         done_q <= done_nx;
      end
   end

   assign bus.stall   = stall;
   assign bus.mc_busy = (state == BUSY);
   assign bus.mc_done = done_q;

`ifdef STALL_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [15:0] ops_cnt;

   // Both counters stick at all-ones rather than wrap
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= 32'd0;
         ops_cnt   <= 16'd0;
      end else if (bus.perf_clr) begin
         stall_cnt <= 32'd0;
         ops_cnt   <= 16'd0;
      end else begin
         if (stall[0] && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
         if (done_q && (ops_cnt != 16'hFFFF))
            ops_cnt <= ops_cnt + 16'd1;
      end
   end

   assign bus.stall_cycles = stall_cnt;
   assign bus.mc_ops       = ops_cnt;
`else
   assign bus.stall_cycles = 32'd0;
   assign bus.mc_ops       = 16'd0;
`endif

endmodule
